// File: rtl/bram_port_arbiter_if.sv
// Signal bundle between the clients, the port arbiter and the shared simple dual-port BRAM.
// The slave modport is the arbiter's view; the master modport is the clients-plus-BRAM side.
interface bram_port_arbiter_if #(
    parameter int NUM_CLIENTS = 4,
    parameter int WIDTH       = 8,
    parameter int LOG2_DEPTH  = 5
);
    logic [NUM_CLIENTS-1:0]            client_we;
    logic [NUM_CLIENTS*LOG2_DEPTH-1:0] client_waddr;
    logic [NUM_CLIENTS*WIDTH-1:0]      client_wdata;
    logic [NUM_CLIENTS-1:0]            client_wgrant;
    logic [NUM_CLIENTS-1:0]            client_re;
    logic [NUM_CLIENTS*LOG2_DEPTH-1:0] client_raddr;
    logic [NUM_CLIENTS-1:0]            client_rlock;
    logic [NUM_CLIENTS-1:0]            client_rgrant;
    logic [NUM_CLIENTS-1:0]            client_rvalid;
    logic [WIDTH-1:0]                  client_rdata;
    logic                              bram_we;
    logic [LOG2_DEPTH-1:0]             bram_waddr;
    logic [WIDTH-1:0]                  bram_wdata;
    logic                              bram_re;
    logic [LOG2_DEPTH-1:0]             bram_raddr;
    logic                              bram_rvalid;
    logic [WIDTH-1:0]                  bram_rdata;

    modport slave (
        input  client_we, client_waddr, client_wdata,
        input  client_re, client_raddr, client_rlock,
        input  bram_rvalid, bram_rdata,
        output client_wgrant, client_rgrant, client_rvalid, client_rdata,
        output bram_we, bram_waddr, bram_wdata,
        output bram_re, bram_raddr
    );

    modport master (
        output client_we, client_waddr, client_wdata,
        output client_re, client_raddr, client_rlock,
        output bram_rvalid, bram_rdata,
        input  client_wgrant, client_rgrant, client_rvalid, client_rdata,
        input  bram_we, bram_waddr, bram_wdata,
        input  bram_re, bram_raddr
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Shares one simple dual-port BRAM among NUM_CLIENTS requesters with independent round-robin
// write and read arbiters, a read-burst lock, and a one-stage tag that steers read responses back.
module bram_port_arbiter #(
    parameter int NUM_CLIENTS = 4,
    parameter int WIDTH       = 8,
    parameter int LOG2_DEPTH  = 5
) (
    input logic                clk,
    input logic                reset,
    bram_port_arbiter_if.slave bus
);
    localparam int PW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    logic [PW-1:0]          wptr;
    logic [PW-1:0]          rptr;
    logic                   lock_active;
    logic [PW-1:0]          lock_owner;
    logic [NUM_CLIENTS-1:0] rtag;
    logic [NUM_CLIENTS-1:0] rreq;
    logic [PW:0]            wpick;
    logic [PW:0]            rpick;
    logic                   wfound;
    logic                   rfound;
    logic [PW-1:0]          wsel;
    logic [PW-1:0]          rsel;

    // Returns {found, index} of the first requester at or above ptr, wrapping modulo NUM_CLIENTS.
    // Scanning downward lets the candidate closest to ptr overwrite the others.
    function automatic logic [PW:0] rr_pick(input logic [NUM_CLIENTS-1:0] req,
                                            input logic [PW-1:0]          ptr);
        logic [PW:0] result;
        logic [PW:0] idx;
        result = '0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(NUM_CLIENTS)) begin
                idx = idx - (PW+1)'(NUM_CLIENTS);
            end
            if (req[idx[PW-1:0]]) begin
                result = {1'b1, idx[PW-1:0]};
            end
        end
        return result;
    endfunction

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] g);
        return (g == PW'(NUM_CLIENTS - 1)) ? '0 : g + 1'b1;
    endfunction

    // A held lock masks every other reader, even while the owner is idle.
    always_comb begin
        rreq = bus.client_re;
        if (lock_active) begin
            rreq = bus.client_re & (NUM_CLIENTS'(1) << lock_owner);
        end
    end

    assign wpick  = rr_pick(bus.client_we, wptr);
    assign rpick  = rr_pick(rreq, rptr);
    assign wfound = wpick[PW] & ~reset;
    assign rfound = rpick[PW] & ~reset;
    assign wsel   = wpick[PW-1:0];
    assign rsel   = rpick[PW-1:0];

    always_comb begin
        bus.client_wgrant = '0;
        bus.bram_we       = 1'b0;
        bus.bram_waddr    = '0;
        bus.bram_wdata    = '0;
        if (wfound) begin
            bus.client_wgrant[wsel] = 1'b1;
            bus.bram_we             = 1'b1;
            bus.bram_waddr          = bus.client_waddr[wsel*LOG2_DEPTH +: LOG2_DEPTH];
            bus.bram_wdata          = bus.client_wdata[wsel*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        bus.client_rgrant = '0;
        bus.bram_re       = 1'b0;
        bus.bram_raddr    = '0;
        if (rfound) begin
            bus.client_rgrant[rsel] = 1'b1;
            bus.bram_re             = 1'b1;
            bus.bram_raddr          = bus.client_raddr[rsel*LOG2_DEPTH +: LOG2_DEPTH];
        end
    end

    // Gating with reset drops a response whose grant was issued just before reset asserted.
    assign bus.client_rvalid = reset ? '0 : (rtag & {NUM_CLIENTS{bus.bram_rvalid}});
    assign bus.client_rdata  = reset ? '0 : bus.bram_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr        <= '0;
            rptr        <= '0;
            lock_active <= 1'b0;
            lock_owner  <= '0;
            rtag        <= '0;
        end else begin
            rtag <= bus.client_rgrant;
            if (wfound) begin
                wptr <= next_ptr(wsel);
            end
            if (rfound) begin
                rptr        <= next_ptr(rsel);
                lock_active <= bus.client_rlock[rsel];
                lock_owner  <= rsel;
            end
        end
    end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with an attached BRAM model and a per-cycle behavioural
// reference (pointers, lock and a shadow memory held as plain integers) checked on every falling edge.
module tb_bram_port_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int L = 5;

    logic clk;
    logic reset;

    bram_port_arbiter_if #(.NUM_CLIENTS(N), .WIDTH(W), .LOG2_DEPTH(L)) bus ();

    bram_port_arbiter #(.NUM_CLIENTS(N), .WIDTH(W), .LOG2_DEPTH(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    logic [L-1:0] wa_v [N];
    logic [W-1:0] wd_v [N];
    logic [L-1:0] ra_v [N];

    // BRAM with one-cycle read latency and read-before-write on address collisions.
    logic [W-1:0] mem [0:(1<<L)-1];
    always @(posedge clk) begin
        bus.bram_rvalid <= bus.bram_re;
        if (bus.bram_re) bus.bram_rdata <= mem[bus.bram_raddr];
        if (bus.bram_we) mem[bus.bram_waddr] <= bus.bram_wdata;
    end

    // Reference state: integer pointers, lock owner, pending response and shadow memory.
    int           m_wptr, m_rptr, m_owner, m_pend_c;
    bit           m_lock, m_pend_v;
    logic [W-1:0] m_pend_d;
    logic [W-1:0] shadow [0:(1<<L)-1];
    int           ew = -1;
    int           er = -1;

    function automatic int rrPick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            int c;
            c = (ptr + k) % N;
            if (((req >> c) & 1) != 0) return c;
        end
        return -1;
    endfunction

    function automatic int wa(input int i);
        return int'(bus.client_waddr[i*L +: L]);
    endfunction

    function automatic int ra(input int i);
        return int'(bus.client_raddr[i*L +: L]);
    endfunction

    function automatic int wd(input int i);
        return int'(bus.client_wdata[i*W +: W]);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge and returns at the following falling edge.
    task automatic applyStimulus(input logic rst, input logic [N-1:0] we, input logic [N-1:0] re,
                                 input logic [N-1:0] rlock);
        @(posedge clk);
        #1;
        reset            = rst;
        bus.client_we    = we;
        bus.client_re    = re;
        bus.client_rlock = rlock;
        for (int i = 0; i < N; i++) begin
            bus.client_waddr[i*L +: L] = wa_v[i];
            bus.client_wdata[i*W +: W] = wd_v[i];
            bus.client_raddr[i*L +: L] = ra_v[i];
        end
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_wptr   = 0;
            m_rptr   = 0;
            m_lock   = 0;
            m_owner  = 0;
            m_pend_v = 0;
        end else begin
            m_pend_v = (er >= 0);
            if (er >= 0) begin
                m_pend_c = er;
                m_pend_d = shadow[ra(er)];
                m_rptr   = (er + 1) % N;
                m_lock   = bus.client_rlock[er];
                m_owner  = er;
            end
            if (ew >= 0) begin
                shadow[wa(ew)] = W'(wd(ew));
                m_wptr         = (ew + 1) % N;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] ewg, erg, erv;
        if (reset) begin
            ew = -1;
            er = -1;
        end else begin
            ew = rrPick(bus.client_we, m_wptr);
            if (m_lock) er = (((bus.client_re >> m_owner) & 1) != 0) ? m_owner : -1;
            else        er = rrPick(bus.client_re, m_rptr);
        end
        ewg = (ew >= 0) ? (N'(1) << ew) : '0;
        erg = (er >= 0) ? (N'(1) << er) : '0;
        erv = (!reset && m_pend_v) ? (N'(1) << m_pend_c) : '0;
        checkOutput("cmp_wgrant",     32'(bus.client_wgrant), 32'(ewg));
        checkOutput("cmp_bram_we",    32'(bus.bram_we),       32'(ew >= 0));
        checkOutput("cmp_bram_waddr", 32'(bus.bram_waddr),    (ew >= 0) ? wa(ew) : 0);
        checkOutput("cmp_bram_wdata", 32'(bus.bram_wdata),    (ew >= 0) ? wd(ew) : 0);
        checkOutput("cmp_rgrant",     32'(bus.client_rgrant), 32'(erg));
        checkOutput("cmp_bram_re",    32'(bus.bram_re),       32'(er >= 0));
        checkOutput("cmp_bram_raddr", 32'(bus.bram_raddr),    (er >= 0) ? ra(er) : 0);
        checkOutput("cmp_rvalid",     32'(bus.client_rvalid), 32'(erv));
        if (erv != 0) checkOutput("cmp_rdata", 32'(bus.client_rdata), 32'(m_pend_d));
    end

    initial begin
        reset            = 1'b1;
        bus.client_we    = '0;
        bus.client_re    = '0;
        bus.client_rlock = '0;
        bus.client_waddr = '0;
        bus.client_wdata = '0;
        bus.client_raddr = '0;
        for (int i = 0; i < N; i++) begin
            wa_v[i] = '0;
            wd_v[i] = '0;
            ra_v[i] = '0;
        end

        applyStimulus(1'b1, 4'b1111, 4'b1111, 4'b0000);
        checkOutput("rst_wgrant",  32'(bus.client_wgrant), 0);
        checkOutput("rst_rgrant",  32'(bus.client_rgrant), 0);
        checkOutput("rst_bram_we", 32'(bus.bram_we), 0);
        checkOutput("rst_bram_re", 32'(bus.bram_re), 0);
        applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000);

        wa_v[2] = 5'd5;
        wd_v[2] = 8'hA5;
        applyStimulus(1'b0, 4'b0100, 4'b0000, 4'b0000);
        checkOutput("single_wgrant", 32'(bus.client_wgrant), 32'b0100);
        checkOutput("single_we",     32'(bus.bram_we), 1);
        checkOutput("single_waddr",  32'(bus.bram_waddr), 5);
        checkOutput("single_wdata",  32'(bus.bram_wdata), 32'hA5);
        ra_v[2] = 5'd5;
        applyStimulus(1'b0, 4'b0000, 4'b0100, 4'b0000);
        checkOutput("single_rgrant", 32'(bus.client_rgrant), 32'b0100);
        checkOutput("single_raddr",  32'(bus.bram_raddr), 5);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000);
        checkOutput("single_rvalid", 32'(bus.client_rvalid), 32'b0100);
        checkOutput("single_rdata",  32'(bus.client_rdata), 32'hA5);
        checkOutput("idle_bram_re",  32'(bus.bram_re), 0);

        // Read pointer sits at 3: client 0 alone wraps, pointer moves to 1 and then holds while idle.
        ra_v[0] = 5'd5;
        applyStimulus(1'b0, 4'b0000, 4'b0001, 4'b0000);
        checkOutput("wrap_rgrant", 32'(bus.client_rgrant), 32'b0001);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000);
        checkOutput("wrap_idle_re",  32'(bus.bram_re), 0);
        checkOutput("wrap_rvalid",   32'(bus.client_rvalid), 32'b0001);
        ra_v[1] = 5'd5;
        applyStimulus(1'b0, 4'b0000, 4'b0011, 4'b0000);
        checkOutput("wrap_hold_rgrant", 32'(bus.client_rgrant), 32'b0010);

        for (int i = 0; i < N; i++) begin
            wa_v[i] = L'(10 + i);
            wd_v[i] = W'(8'h30 + i);
            applyStimulus(1'b0, N'(1) << i, 4'b0000, 4'b0000);
            checkOutput("fill_wgrant", 32'(bus.client_wgrant), 32'(1 << i));
        end

        applyStimulus(1'b1, 4'b0000, 4'b0000, 4'b0000);
        for (int i = 0; i < N; i++) ra_v[i] = L'(10 + i);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 4'b0000, 4'b1111, 4'b0000);
            checkOutput("fair_rgrant", 32'(bus.client_rgrant), 32'(1 << (k % 4)));
            if (k > 0) begin
                checkOutput("fair_rvalid", 32'(bus.client_rvalid), 32'(1 << ((k - 1) % 4)));
                checkOutput("fair_rdata",  32'(bus.client_rdata), 32'(8'h30 + (k - 1) % 4));
            end
        end
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000);
        checkOutput("fair_last_rvalid", 32'(bus.client_rvalid), 32'b1000);
        checkOutput("fair_last_rdata",  32'(bus.client_rdata), 32'h33);

        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 4'b0000, 4'b1010, (k < 3) ? 4'b0010 : 4'b0000);
            checkOutput("lock_burst_rgrant", 32'(bus.client_rgrant), 32'b0010);
        end
        applyStimulus(1'b0, 4'b0000, 4'b1000, 4'b0000);
        checkOutput("lock_release_rgrant", 32'(bus.client_rgrant), 32'b1000);

        // Owner idle under lock: client 2 stalls while the write port still serves client 3.
        ra_v[0] = 5'd12;
        ra_v[2] = 5'd10;
        applyStimulus(1'b0, 4'b0000, 4'b0001, 4'b0001);
        checkOutput("stall_lock_rgrant", 32'(bus.client_rgrant), 32'b0001);
        wa_v[3] = 5'd20;
        wd_v[3] = 8'h5C;
        applyStimulus(1'b0, 4'b1000, 4'b0100, 4'b0000);
        checkOutput("stall_rgrant", 32'(bus.client_rgrant), 32'b0000);
        checkOutput("stall_wgrant", 32'(bus.client_wgrant), 32'b1000);
        applyStimulus(1'b0, 4'b0000, 4'b0101, 4'b0000);
        checkOutput("stall_owner_rgrant", 32'(bus.client_rgrant), 32'b0001);
        applyStimulus(1'b0, 4'b0000, 4'b0100, 4'b0000);
        checkOutput("stall_after_rgrant", 32'(bus.client_rgrant), 32'b0100);

        wa_v[0] = 5'd7;
        wd_v[0] = 8'h11;
        applyStimulus(1'b0, 4'b0001, 4'b0000, 4'b0000);
        checkOutput("coll_init_wgrant", 32'(bus.client_wgrant), 32'b0001);
        wd_v[0] = 8'h22;
        ra_v[1] = 5'd7;
        applyStimulus(1'b0, 4'b0001, 4'b0010, 4'b0000);
        checkOutput("coll_wgrant", 32'(bus.client_wgrant), 32'b0001);
        checkOutput("coll_rgrant", 32'(bus.client_rgrant), 32'b0010);
        applyStimulus(1'b0, 4'b0000, 4'b0010, 4'b0000);
        checkOutput("coll_old_rdata", 32'(bus.client_rdata), 32'h11);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000);
        checkOutput("coll_new_rvalid", 32'(bus.client_rvalid), 32'b0010);
        checkOutput("coll_new_rdata",  32'(bus.client_rdata), 32'h22);

        // Client 3 takes a locked read, then reset must drop its response and clear lock and pointers.
        wa_v[1] = 5'd3;
        wd_v[1] = 8'h77;
        ra_v[3] = 5'd12;
        applyStimulus(1'b0, 4'b0010, 4'b1000, 4'b1000);
        checkOutput("mid_rgrant", 32'(bus.client_rgrant), 32'b1000);
        checkOutput("mid_wgrant", 32'(bus.client_wgrant), 32'b0010);
        ra_v[1] = 5'd10;
        ra_v[2] = 5'd11;
        wa_v[0] = 5'd4;
        wd_v[0] = 8'h40;
        wa_v[3] = 5'd6;
        wd_v[3] = 8'h60;
        applyStimulus(1'b1, 4'b1001, 4'b0110, 4'b0000);
        checkOutput("mid_rst_rvalid", 32'(bus.client_rvalid), 0);
        checkOutput("mid_rst_rgrant", 32'(bus.client_rgrant), 0);
        checkOutput("mid_rst_wgrant", 32'(bus.client_wgrant), 0);
        checkOutput("mid_rst_we",     32'(bus.bram_we), 0);
        applyStimulus(1'b1, 4'b1001, 4'b0110, 4'b0000);
        checkOutput("mid_rst2_rgrant", 32'(bus.client_rgrant), 0);
        applyStimulus(1'b0, 4'b1001, 4'b0110, 4'b0000);
        checkOutput("post_rst_rgrant", 32'(bus.client_rgrant), 32'b0010);
        checkOutput("post_rst_wgrant", 32'(bus.client_wgrant), 32'b0001);
        applyStimulus(1'b0, 4'b0000, 4'b0000, 4'b0000);
        checkOutput("post_rst_rvalid", 32'(bus.client_rvalid), 32'b0010);
        checkOutput("post_rst_rdata",  32'(bus.client_rdata), 32'h30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
